// File: rtl/sudoku_session_ctrl.sv
// Top-level session sequencer for the Sudoku board.
// Clears the 81-cell board, runs cursor-based puzzle entry, hands the board
// port to the solver while solving, then allows read-only result browsing.
// Ports:
//   Clk, Reset                 clock, async active-high reset
//   Start/Prev/Next/Enter      debounced single-cycle button pulses
//   InputValue                 digit to enter (0 = blank)
//   SolveReq/SolveDone/Fail    solver handshake
//   SlvWe/SlvAddr/SlvWData     solver memory request, SlvGnt = solver owns port
//   MemAddr/MemWe/MemWData/MemFixedWr/MemRData   board RAM port
//   Row/Col/CurValue           cursor position and registered digit at cursor
//   Clear/Entry/Solve/Disp/Fail  one-hot state flags
module sudoku_session_ctrl #(
  parameter int unsigned SOLVE_TIMEOUT = 0,
  parameter int unsigned TMO_W         = 24
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Prev,
  input  logic             Next,
  input  logic             Enter,
  input  logic [3:0]       InputValue,
  output logic             SolveReq,
  input  logic             SolveDone,
  input  logic             SolveFail,
  input  logic             SlvWe,
  input  logic [6:0]       SlvAddr,
  input  logic [3:0]       SlvWData,
  output logic             SlvGnt,
  output logic [6:0]       MemAddr,
  output logic             MemWe,
  output logic [3:0]       MemWData,
  output logic             MemFixedWr,
  input  logic [3:0]       MemRData,
  output logic [3:0]       Row,
  output logic [3:0]       Col,
  output logic [3:0]       CurValue,
  output logic             Clear,
  output logic             Entry,
  output logic             Solve,
  output logic             Disp,
  output logic             Fail
);

  localparam int unsigned ST_W = 5;
  localparam int unsigned AW   = 7;
  localparam int unsigned DW   = 4;
  localparam int unsigned CW   = 4;

  localparam int unsigned S_CLEAR = 0;
  localparam int unsigned S_ENTRY = 1;
  localparam int unsigned S_SOLVE = 2;
  localparam int unsigned S_DISP  = 3;
  localparam int unsigned S_FAIL  = 4;

  localparam logic [ST_W-1:0] ST_CLEAR = 5'b00001;
  localparam logic [ST_W-1:0] ST_ENTRY = 5'b00010;
  localparam logic [ST_W-1:0] ST_SOLVE = 5'b00100;
  localparam logic [ST_W-1:0] ST_DISP  = 5'b01000;
  localparam logic [ST_W-1:0] ST_FAIL  = 5'b10000;

  localparam logic [AW-1:0] LAST_CELL = 7'd80;
  localparam logic [CW-1:0] MAX_RC    = 4'd8;
  localparam logic [DW-1:0] MAX_DIGIT = 4'd9;

  logic [ST_W-1:0]  state_q, state_d;
  logic [AW-1:0]    clr_q, clr_d;
  logic [CW-1:0]    row_q, row_d, col_q, col_d;
  logic [DW-1:0]    cur_q, cur_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             wr_q, wr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             fixed_q, fixed_d;

  logic             tmo_hit;
  logic             browse;
  logic             mv_en;
  logic [AW-1:0]    ui_addr;

  assign tmo_hit = (SOLVE_TIMEOUT != 0) && (tmo_q == TMO_W'(SOLVE_TIMEOUT - 1));
  assign browse  = state_q[S_DISP] | state_q[S_FAIL];
  // Cursor moves only when no higher-priority button is active this cycle.
  assign mv_en   = (state_q[S_ENTRY] & ~Start & ~Enter) | (browse & ~Enter);
  assign ui_addr = AW'(row_q) * AW'(9) + AW'(col_q);

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q[S_CLEAR]) begin
      if (clr_q == LAST_CELL) state_d = ST_ENTRY;
    end else if (state_q[S_ENTRY]) begin
      if (Start) state_d = ST_SOLVE;
    end else if (state_q[S_SOLVE]) begin
      // Failure outranks success; a solver response outranks the timeout.
      if (SolveFail)      state_d = ST_FAIL;
      else if (SolveDone) state_d = ST_DISP;
      else if (tmo_hit)   state_d = ST_FAIL;
    end else if (browse) begin
      if (Enter) state_d = ST_CLEAR;
    end else begin
      state_d = ST_CLEAR;
    end
  end

  // Datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clr_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cur_q   <= '0;
      tmo_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      fixed_q <= 1'b0;
    end else begin
      clr_q   <= clr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cur_q   <= cur_d;
      tmo_q   <= tmo_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      fixed_q <= fixed_d;
    end
  end

  // Datapath next values: clear sweep, cursor, entry write, timeout, read-back
  always_comb begin
    clr_d   = '0;
    row_d   = row_q;
    col_d   = col_q;
    cur_d   = cur_q;
    tmo_d   = '0;
    wr_d    = 1'b0;
    wdata_d = '0;
    fixed_d = 1'b0;

    if (state_q[S_CLEAR]) begin
      clr_d = (clr_q == LAST_CELL) ? '0 : clr_q + AW'(1);
      row_d = '0;
      col_d = '0;
    end

    if (state_q[S_SOLVE]) tmo_d = tmo_q + TMO_W'(1);

    if (state_q[S_ENTRY] && !Start && Enter && (InputValue <= MAX_DIGIT)) begin
      wr_d    = 1'b1;
      wdata_d = InputValue;
      fixed_d = (InputValue != '0);
    end

    if (browse && Enter) begin
      row_d = '0;
      col_d = '0;
    end

    // Row-major stepping with wrap at both ends; both buttons cancel out.
    if (mv_en && (Next ^ Prev)) begin
      if (Next) begin
        if (col_q == MAX_RC) begin
          col_d = '0;
          row_d = (row_q == MAX_RC) ? '0 : row_q + CW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end else begin
        if (col_q == '0) begin
          col_d = MAX_RC;
          row_d = (row_q == '0) ? MAX_RC : row_q - CW'(1);
        end else begin
          col_d = col_q - CW'(1);
        end
      end
    end

    if (state_q[S_ENTRY] || browse) cur_d = MemRData;
  end

  // Board port arbitration and outputs
  always_comb begin
    MemAddr    = ui_addr;
    MemWe      = 1'b0;
    MemWData   = '0;
    MemFixedWr = 1'b0;
    if (state_q[S_SOLVE]) begin
      MemAddr  = SlvAddr;
      MemWe    = SlvWe;
      MemWData = SlvWData;
    end else if (state_q[S_CLEAR]) begin
      // Strobe held off while reset is asserted.
      MemAddr = clr_q;
      MemWe   = ~Reset;
    end else begin
      MemWe      = wr_q;
      MemWData   = wdata_q;
      MemFixedWr = fixed_q;
    end
  end

  assign SolveReq = state_q[S_SOLVE];
  assign SlvGnt   = state_q[S_SOLVE];
  assign Clear    = state_q[S_CLEAR];
  assign Entry    = state_q[S_ENTRY];
  assign Solve    = state_q[S_SOLVE];
  assign Disp     = state_q[S_DISP];
  assign Fail     = state_q[S_FAIL];
  assign Row      = row_q;
  assign Col      = col_q;
  assign CurValue = cur_q;

endmodule

// File: tb/tb_sudoku_session_ctrl.sv
// Directed bench for sudoku_session_ctrl: one instance with a 100-cycle solve
// timeout (driving a small board RAM model) and one with the timeout disabled,
// both fed the same stimulus.
module tb_sudoku_session_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Start, Prev, Next, Enter;
  logic [3:0] InputValue;
  logic       SolveDone, SolveFail, SlvWe;
  logic [6:0] SlvAddr;
  logic [3:0] SlvWData;
  logic [3:0] MemRData;

  logic       SolveReq, SlvGnt, MemWe, MemFixedWr;
  logic [6:0] MemAddr;
  logic [3:0] MemWData, Row, Col, CurValue;
  logic       Clear, Entry, Solve, Disp, Fail;

  logic       d0_SolveReq, d0_SlvGnt, d0_MemWe, d0_MemFixedWr;
  logic [6:0] d0_MemAddr;
  logic [3:0] d0_MemWData, d0_Row, d0_Col, d0_CurValue;
  logic       d0_Clear, d0_Entry, d0_Solve, d0_Disp, d0_Fail;

  logic [3:0] ram [0:127];

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  // Write-first board RAM, read data valid one cycle after the address.
  always @(posedge Clk) begin
    if (MemWe) begin
      ram[MemAddr] <= MemWData;
      MemRData     <= MemWData;
    end else begin
      MemRData <= ram[MemAddr];
    end
  end

  sudoku_session_ctrl #(.SOLVE_TIMEOUT(100), .TMO_W(24)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Prev(Prev), .Next(Next),
    .Enter(Enter), .InputValue(InputValue), .SolveReq(SolveReq),
    .SolveDone(SolveDone), .SolveFail(SolveFail), .SlvWe(SlvWe),
    .SlvAddr(SlvAddr), .SlvWData(SlvWData), .SlvGnt(SlvGnt),
    .MemAddr(MemAddr), .MemWe(MemWe), .MemWData(MemWData),
    .MemFixedWr(MemFixedWr), .MemRData(MemRData), .Row(Row), .Col(Col),
    .CurValue(CurValue), .Clear(Clear), .Entry(Entry), .Solve(Solve),
    .Disp(Disp), .Fail(Fail)
  );

  sudoku_session_ctrl u_dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Prev(Prev), .Next(Next),
    .Enter(Enter), .InputValue(InputValue), .SolveReq(d0_SolveReq),
    .SolveDone(SolveDone), .SolveFail(SolveFail), .SlvWe(SlvWe),
    .SlvAddr(SlvAddr), .SlvWData(SlvWData), .SlvGnt(d0_SlvGnt),
    .MemAddr(d0_MemAddr), .MemWe(d0_MemWe), .MemWData(d0_MemWData),
    .MemFixedWr(d0_MemFixedWr), .MemRData(MemRData), .Row(d0_Row),
    .Col(d0_Col), .CurValue(d0_CurValue), .Clear(d0_Clear),
    .Entry(d0_Entry), .Solve(d0_Solve), .Disp(d0_Disp), .Fail(d0_Fail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expects to start in the first CLEAR cycle; ends in the first ENTRY cycle.
  task automatic run_clear();
    for (int i = 0; i < 81; i++) begin
      chk("clr_addr", 32'(MemAddr), 32'(i));
      chk("clr_we", 32'(MemWe), 32'd1);
      chk("clr_data", 32'(MemWData), 32'd0);
      tick();
    end
    chk("clr_done_entry", 32'(Entry), 32'd1);
    chk("clr_done_clear", 32'(Clear), 32'd0);
    chk("clr_done_row", 32'(Row), 32'd0);
    chk("clr_done_col", 32'(Col), 32'd0);
    chk("clr_done_we", 32'(MemWe), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Prev = 1'b0; Next = 1'b0; Enter = 1'b0;
    InputValue = '0; SolveDone = 1'b0; SolveFail = 1'b0; SlvWe = 1'b0;
    SlvAddr = '0; SlvWData = '0;
    for (int i = 0; i < 128; i++) ram[i] = 4'hF;

    // Reset values
    tick(); tick();
    chk("rst_clear", 32'(Clear), 32'd1);
    chk("rst_entry", 32'(Entry), 32'd0);
    chk("rst_solvereq", 32'(SolveReq), 32'd0);
    chk("rst_slvgnt", 32'(SlvGnt), 32'd0);
    chk("rst_memwe", 32'(MemWe), 32'd0);
    chk("rst_wdata", 32'(MemWData), 32'd0);
    chk("rst_fixed", 32'(MemFixedWr), 32'd0);
    chk("rst_row", 32'(Row), 32'd0);
    chk("rst_col", 32'(Col), 32'd0);
    chk("rst_cur", 32'(CurValue), 32'd0);

    Reset = 1'b0; #1;
    run_clear();

    // 80 Next moves to the last cell, checking the column-8 wrap on the way
    Next = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (i == 9) begin
        chk("next_wrap_row", 32'(Row), 32'd1);
        chk("next_wrap_col", 32'(Col), 32'd0);
      end
    end
    Next = 1'b0;
    chk("last_row", 32'(Row), 32'd8);
    chk("last_col", 32'(Col), 32'd8);
    chk("last_addr", 32'(MemAddr), 32'd80);
    Next = 1'b1; tick(); Next = 1'b0;
    chk("next_wrap00_row", 32'(Row), 32'd0);
    chk("next_wrap00_col", 32'(Col), 32'd0);
    Prev = 1'b1; tick(); Prev = 1'b0;
    chk("prev_wrap88_row", 32'(Row), 32'd8);
    chk("prev_wrap88_col", 32'(Col), 32'd8);
    Prev = 1'b1; Next = 1'b1; tick(); Prev = 1'b0; Next = 1'b0;
    chk("both_row", 32'(Row), 32'd8);
    chk("both_col", 32'(Col), 32'd8);

    // Move to (2,3): one wrap to (0,0) plus 21 steps
    Next = 1'b1;
    for (int i = 0; i < 22; i++) tick();
    Next = 1'b0;
    chk("cur23_row", 32'(Row), 32'd2);
    chk("cur23_col", 32'(Col), 32'd3);
    chk("cur23_addr", 32'(MemAddr), 32'd21);

    // Fixed digit write
    InputValue = 4'd7; Enter = 1'b1; tick(); Enter = 1'b0;
    chk("wr7_we", 32'(MemWe), 32'd1);
    chk("wr7_addr", 32'(MemAddr), 32'd21);
    chk("wr7_data", 32'(MemWData), 32'd7);
    chk("wr7_fixed", 32'(MemFixedWr), 32'd1);
    chk("wr7_row", 32'(Row), 32'd2);
    tick();
    chk("wr7_single", 32'(MemWe), 32'd0);
    chk("cur_lag1", 32'(CurValue), 32'd0);
    tick();
    chk("cur_lag2", 32'(CurValue), 32'd7);

    // Out-of-range digit ignored
    InputValue = 4'd12; Enter = 1'b1; tick(); Enter = 1'b0;
    chk("wr12_we", 32'(MemWe), 32'd0);
    tick();
    chk("wr12_we2", 32'(MemWe), 32'd0);

    // Blank write
    InputValue = 4'd0; Enter = 1'b1; tick(); Enter = 1'b0;
    chk("wr0_we", 32'(MemWe), 32'd1);
    chk("wr0_addr", 32'(MemAddr), 32'd21);
    chk("wr0_data", 32'(MemWData), 32'd0);
    chk("wr0_fixed", 32'(MemFixedWr), 32'd0);
    tick();

    // Start with Enter: Start wins
    InputValue = 4'd5; Start = 1'b1; Enter = 1'b1; tick(); Start = 1'b0; Enter = 1'b0;
    chk("slv_solve", 32'(Solve), 32'd1);
    chk("slv_req", 32'(SolveReq), 32'd1);
    chk("slv_gnt", 32'(SlvGnt), 32'd1);
    chk("slv_no_ui_wr", 32'(MemWe), 32'd0);
    chk("slv_d0_solve", 32'(d0_Solve), 32'd1);
    SlvWe = 1'b1; SlvAddr = 7'd40; SlvWData = 4'd5; Next = 1'b1; #1;
    chk("slv_pass_we", 32'(MemWe), 32'd1);
    chk("slv_pass_addr", 32'(MemAddr), 32'd40);
    chk("slv_pass_data", 32'(MemWData), 32'd5);
    chk("slv_pass_fixed", 32'(MemFixedWr), 32'd0);
    tick(); SlvWe = 1'b0; Next = 1'b0;
    chk("slv_hold_row", 32'(Row), 32'd2);
    chk("slv_hold_col", 32'(Col), 32'd3);

    // Solver success
    SolveDone = 1'b1; tick(); SolveDone = 1'b0;
    chk("done_disp", 32'(Disp), 32'd1);
    chk("done_req", 32'(SolveReq), 32'd0);
    chk("done_gnt", 32'(SlvGnt), 32'd0);
    chk("done_d0_disp", 32'(d0_Disp), 32'd1);
    SlvWe = 1'b1; SlvAddr = 7'd40; #1;
    chk("disp_slv_blocked", 32'(MemWe), 32'd0);
    chk("disp_ui_addr", 32'(MemAddr), 32'd21);
    SlvWe = 1'b0;

    // Browse: Prev across column 0 into the previous row
    Prev = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    Prev = 1'b0;
    chk("prev_row", 32'(Row), 32'd1);
    chk("prev_col", 32'(Col), 32'd8);
    Start = 1'b1; tick(); Start = 1'b0;
    chk("disp_start_ign", 32'(Disp), 32'd1);
    Next = 1'b1;
    for (int i = 0; i < 23; i++) tick();
    Next = 1'b0;
    chk("browse_addr", 32'(MemAddr), 32'd40);
    chk("browse_we", 32'(MemWe), 32'd0);
    tick(); tick();
    chk("browse_cur", 32'(CurValue), 32'd5);
    chk("browse_d0_cur", 32'(d0_CurValue), 32'd5);

    // New puzzle
    Enter = 1'b1; tick(); Enter = 1'b0;
    chk("restart_clear", 32'(Clear), 32'd1);
    chk("restart_row", 32'(Row), 32'd0);
    run_clear();
    chk("ram40_cleared", 32'(ram[40]), 32'd0);
    chk("ram21_cleared", 32'(ram[21]), 32'd0);

    // Timeout with a silent solver
    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    chk("tmo_still_solve", 32'(Solve), 32'd1);
    tick();
    chk("tmo_fail", 32'(Fail), 32'd1);
    chk("tmo_req", 32'(SolveReq), 32'd0);
    chk("tmo_gnt", 32'(SlvGnt), 32'd0);
    chk("tmo_d0_solve", 32'(d0_Solve), 32'd1);

    // Reset mid-SOLVE on the no-timeout instance
    Reset = 1'b1; #1;
    chk("rst_mid_req", 32'(d0_SolveReq), 32'd0);
    chk("rst_mid_gnt", 32'(d0_SlvGnt), 32'd0);
    chk("rst_mid_clear", 32'(d0_Clear), 32'd1);
    chk("rst_mid_d1_clear", 32'(Clear), 32'd1);
    tick();
    Reset = 1'b0; #1;
    run_clear();

    // Simultaneous done and fail: fail wins
    Start = 1'b1; tick(); Start = 1'b0;
    SolveDone = 1'b1; SolveFail = 1'b1; tick(); SolveDone = 1'b0; SolveFail = 1'b0;
    chk("both_fail", 32'(Fail), 32'd1);
    chk("both_disp", 32'(Disp), 32'd0);
    chk("both_d0_fail", 32'(d0_Fail), 32'd1);
    Prev = 1'b1; tick(); Prev = 1'b0;
    chk("fail_prev_row", 32'(Row), 32'd8);
    chk("fail_prev_col", 32'(Col), 32'd8);
    Enter = 1'b1; tick(); Enter = 1'b0;
    chk("fail_enter_clear", 32'(Clear), 32'd1);
    chk("fail_enter_addr", 32'(MemAddr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sudoku_session_ctrl.md
Name: sudoku_session_ctrl

Overview:
- Top-level sequencer for the Sudoku board: clears the 81-cell board memory, runs user puzzle entry with a cursor, hands the board to the backtracking solver, then runs result browsing.
- Sole owner of the board memory port. Arbitrates it between the user-entry path and the solver: the solver is granted only in SOLVE.
- Sits between debounced button pulses and the solver core and board RAM.

Parameters:
- SOLVE_TIMEOUT, default 0: solver cycle budget; 0 disables the timeout.
- TMO_W, default 24: width of the timeout counter.

Ports:
- Clk  in  1  system clock
- Reset  in  1  async active-high reset
- Start  in  1  single-cycle pulse; begin solving
- Prev  in  1  single-cycle pulse; move cursor back
- Next  in  1  single-cycle pulse; move cursor forward
- Enter  in  1  single-cycle pulse; write cell / restart
- InputValue  in  4  digit to enter (0 = blank)
- SolveReq  out  1  level; solver run request
- SolveDone  in  1  single-cycle pulse; solver succeeded
- SolveFail  in  1  single-cycle pulse; solver exhausted
- SlvWe  in  1  solver write enable
- SlvAddr  in  7  solver cell address 0..80
- SlvWData  in  4  solver write digit
- SlvGnt  out  1  solver owns memory port
- MemAddr  out  7  board address = Row*9+Col (UI) or SlvAddr
- MemWe  out  1  board write strobe
- MemWData  out  4  board write digit
- MemFixedWr  out  1  fixed-flag value written with MemWe
- MemRData  in  4  board read data, valid 1 cycle after MemAddr
- Row  out  4  cursor row 0..8
- Col  out  4  cursor column 0..8
- CurValue  out  4  registered digit at cursor
- Clear, Entry, Solve, Disp, Fail  out  1 each  one-hot state flags

Behaviour:
- Reset (async, any state incl. mid-SOLVE):
  - state=CLEAR, clear counter=0, Row=Col=0, CurValue=0.
  - SolveReq=0, SlvGnt=0, MemWe=0, MemWData=0, MemFixedWr=0, timeout counter=0.
- Encoding: states CLEAR, ENTRY, SOLVE, DISP, FAIL, one-hot; flags are direct state bits.
- CLEAR:
  - Writes 0 with fixed=0 to addresses 0..80, one per cycle: MemWe=1, MemAddr=counter.
  - After address 80 is written, goes to ENTRY with Row=Col=0. Exactly 81 cycles.
  - All buttons are ignored.
- ENTRY, priority Start > Enter > Prev/Next:
  - Start: goes to SOLVE next cycle; Enter, Prev and Next in the same cycle are ignored.
  - Enter with InputValue<=9: one-cycle write at the cursor, MemWData=InputValue, MemFixedWr=(InputValue!=0). The cursor does not move.
  - Enter with InputValue>9: ignored, no write.
  - Prev/Next without Enter: cursor moves one cell in row-major order.
    - Next at Col=8 goes to Col=0, Row+1. Next at (8,8) wraps to (0,0).
    - Prev at Col=0 goes to Col=8, Row-1. Prev at (0,0) wraps to (8,8).
    - Prev and Next together: no move.
- SOLVE:
  - SolveReq=1, SlvGnt=1. MemAddr/MemWe/MemWData come combinationally from SlvAddr/SlvWe/SlvWData; MemFixedWr=0.
  - UI buttons are ignored and the cursor holds.
  - SolveDone goes to DISP. SolveFail goes to FAIL. If both are high, SolveFail wins.
  - If SOLVE_TIMEOUT!=0 and the counter reaches SOLVE_TIMEOUT-1 with no response, goes to FAIL.
  - The timeout counter clears on SOLVE entry.
  - On leaving SOLVE, SolveReq and SlvGnt drop the same edge the state changes.
- Outside SOLVE: SlvGnt=0 and solver inputs never reach memory.
- DISP and FAIL:
  - Read-only browsing: Prev/Next move the cursor with the same rules; MemWe=0.
  - Enter goes to CLEAR (new puzzle). Start is ignored.
- CurValue: MemRData is registered every cycle in ENTRY/DISP/FAIL, so it lags a cursor move or write by 2 cycles. It holds in CLEAR/SOLVE.
- Row/Col never leave 0..8. MemAddr in UI mode = Row*9+Col, 7-bit, max 80.

Test Plan:
- Reset release → CLEAR for 81 cycles writing addr 0..80 with data 0, then Entry=1, Row=Col=0, MemWe=0.
- ENTRY, 80 Next pulses → (8,8), addr 80. One more Next → (0,0). One Prev → (8,8). Prev+Next together → no change.
- Cursor (2,3), InputValue=7, Enter → single write addr 21, data 7, fixed=1. InputValue=12, Enter → no MemWe. InputValue=0, Enter → write 0 with fixed=0.
- Start with Enter in the same cycle → no write; SOLVE next cycle; SolveReq=SlvGnt=1. SlvWe=1, SlvAddr=40, SlvWData=5 → MemWe=1, addr 40, data 5, same cycle.
- SolveDone pulse → Disp=1, SlvGnt=0; an SlvWe pulse then causes no MemWe. Enter → CLEAR restarts at addr 0.
- SOLVE_TIMEOUT=100, solver silent → Fail=1 after 100 SOLVE cycles. Separately, assert Reset mid-SOLVE → SolveReq=0 immediately, Clear=1.
